// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch sequencer with req/ack memory port and fault detection
// Holds one fetched instruction until consumed, then waits for the downstream next PC.
module fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    input  logic [31:0] next_pc,
    input  logic        pc_update,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err,
    output logic        fetch_fault,
    output logic [31:0] fault_addr,
    output logic        busy
);

    localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        HOLD,
        WAIT_PC,
        FAULT
    } state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] cnt;
    logic          pend_valid;
    logic [31:0]   pend_pc;

    logic          apply;
    logic [31:0]   apply_pc;

    assign mem_addr = fetch_pc;

    // A PC latched early in HOLD takes priority over one arriving with the handshake.
    always_comb begin
        apply    = 1'b0;
        apply_pc = next_pc;
        case (state)
            HOLD: begin
                if (instr_valid && instr_ready) begin
                    if (pend_valid) begin
                        apply    = 1'b1;
                        apply_pc = pend_pc;
                    end else if (pc_update) begin
                        apply = 1'b1;
                    end
                end
            end
            WAIT_PC: begin
                if (pc_update) begin
                    apply = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            cnt         <= '0;
            pend_valid  <= 1'b0;
            pend_pc     <= '0;
            instr       <= '0;
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
            mem_req     <= 1'b0;
            fetch_fault <= 1'b0;
            fault_addr  <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!halt) begin
                        state   <= FETCH;
                        mem_req <= 1'b1;
                        busy    <= 1'b1;
                        cnt     <= '0;
                    end
                end
                FETCH: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        busy    <= 1'b0;
                        if (mem_err) begin
                            state       <= FAULT;
                            fetch_fault <= 1'b1;
                            fault_addr  <= fetch_pc;
                        end else begin
                            state       <= HOLD;
                            instr       <= mem_rdata;
                            pc          <= fetch_pc;
                            instr_valid <= 1'b1;
                            pend_valid  <= 1'b0;
                        end
                    end else if (cnt == CNT_LAST) begin
                        state       <= FAULT;
                        mem_req     <= 1'b0;
                        busy        <= 1'b0;
                        fetch_fault <= 1'b1;
                        fault_addr  <= fetch_pc;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (instr_valid && instr_ready) begin
                        instr_valid <= 1'b0;
                        pend_valid  <= 1'b0;
                        if (!apply) begin
                            state <= WAIT_PC;
                        end
                    end else if (pc_update && !pend_valid) begin
                        pend_valid <= 1'b1;
                        pend_pc    <= next_pc;
                    end
                end
                default: ;
            endcase

            if (apply) begin
                if (apply_pc[1:0] != 2'b00) begin
                    state       <= FAULT;
                    fetch_fault <= 1'b1;
                    fault_addr  <= apply_pc;
                end else begin
                    fetch_pc <= apply_pc;
                    if (!halt) begin
                        state   <= FETCH;
                        mem_req <= 1'b1;
                        busy    <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, halt, pc_update, instr_ready, mem_ack, mem_err;
    logic [31:0] next_pc, mem_rdata;
    logic [31:0] instr, pc, mem_addr, fault_addr;
    logic        instr_valid, mem_req, fetch_fault, busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_addr_q[$];
    logic [63:0] exp_instr_q[$];
    logic        req_q = 1'b0;
    logic [63:0] e_ins;
    logic [31:0] e_addr;

    fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .halt(halt), .next_pc(next_pc), .pc_update(pc_update),
        .instr(instr), .pc(pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .mem_err(mem_err), .fetch_fault(fetch_fault), .fault_addr(fault_addr), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Monitor: consumed instructions and new memory requests are matched against the queues.
    always @(negedge clk) begin
        if (instr_valid && instr_ready) begin
            if (exp_instr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_instr: got %h pc %h expected none", instr, pc);
            end else begin
                e_ins = exp_instr_q.pop_front();
                chk("instr", instr, e_ins[63:32]);
                chk("pc", pc, e_ins[31:0]);
            end
        end
        if (mem_req && !req_q) begin
            if (exp_addr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_req: got addr %h expected none", mem_addr);
            end else begin
                e_addr = exp_addr_q.pop_front();
                chk("req_addr", mem_addr, e_addr);
            end
        end
        req_q <= mem_req;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic serve(input logic [31:0] data, input logic err, input int delay);
        int          n = 0;
        logic [31:0] a;
        while (!mem_req && n < 50) begin
            tick();
            n++;
        end
        chk1("req_seen", mem_req, 1'b1);
        a = mem_addr;
        repeat (delay) begin
            tick();
            chk1("req_stable", mem_req, 1'b1);
            chk("addr_stable", mem_addr, a);
        end
        mem_ack   = 1'b1;
        mem_rdata = data;
        mem_err   = err;
        tick();
        mem_ack   = 1'b0;
        mem_err   = 1'b0;
        mem_rdata = 32'hdead_beef;
    endtask

    task automatic consume(input logic [31:0] np, input logic upd);
        int n = 0;
        while (!instr_valid && n < 50) begin
            tick();
            n++;
        end
        chk1("valid_seen", instr_valid, 1'b1);
        instr_ready = 1'b1;
        pc_update   = upd;
        next_pc     = np;
        tick();
        instr_ready = 1'b0;
        pc_update   = 1'b0;
    endtask

    task automatic pulse(input logic [31:0] np);
        pc_update = 1'b1;
        next_pc   = np;
        tick();
        pc_update = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; halt = 1'b0; pc_update = 1'b0; instr_ready = 1'b0;
        mem_ack = 1'b0; mem_err = 1'b0; next_pc = '0; mem_rdata = '0;
        tick(); tick();
        chk1("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk1("rst_valid", instr_valid, 1'b0);
        chk1("rst_fault", fetch_fault, 1'b0);
        chk("rst_fault_addr", fault_addr, 32'h0);
        chk1("rst_busy", busy, 1'b0);

        // Sequential fetch 0x0 -> 0x4
        exp_addr_q.push_back(32'h0);
        exp_instr_q.push_back({32'h0000_0013, 32'h0});
        rst = 1'b0;
        tick();
        chk1("first_req", mem_req, 1'b1);
        chk1("first_busy", busy, 1'b1);
        serve(32'h0000_0013, 1'b0, 1);
        chk1("valid_after_ack", instr_valid, 1'b1);
        chk1("busy_hold", busy, 1'b0);
        exp_addr_q.push_back(32'h4);
        exp_instr_q.push_back({32'h0040_0093, 32'h4});
        consume(32'h4, 1'b1);
        chk1("seq_req", mem_req, 1'b1);
        chk("seq_addr", mem_addr, 32'h4);
        serve(32'h0040_0093, 1'b0, 1);

        // Handshake without pc_update parks in WAIT_PC
        consume(32'h0, 1'b0);
        tick(); tick();
        chk1("wait_pc_no_req", mem_req, 1'b0);
        exp_addr_q.push_back(32'h10);
        exp_instr_q.push_back({32'h00c0_006f, 32'h10});
        pulse(32'h10);
        chk1("wait_pc_req", mem_req, 1'b1);
        serve(32'h00c0_006f, 1'b0, 2);

        // Taken branch in the handshake cycle, slow memory
        exp_addr_q.push_back(32'h40);
        exp_instr_q.push_back({32'h1111_1111, 32'h40});
        consume(32'h40, 1'b1);
        chk1("branch_req", mem_req, 1'b1);
        chk("branch_addr", mem_addr, 32'h40);
        serve(32'h1111_1111, 1'b0, 5);

        // Early pc_update latched in HOLD; the second pulse is dropped
        tick();
        pulse(32'h50);
        pulse(32'h60);
        tick();
        chk1("hold_valid", instr_valid, 1'b1);
        chk1("hold_no_req", mem_req, 1'b0);
        exp_addr_q.push_back(32'h50);
        consume(32'h0, 1'b0);
        chk1("latched_req", mem_req, 1'b1);
        chk("latched_addr", mem_addr, 32'h50);

        // Halt during an outstanding request
        halt = 1'b1;
        exp_instr_q.push_back({32'h2222_2222, 32'h50});
        serve(32'h2222_2222, 1'b0, 2);
        chk1("halt_delivered", instr_valid, 1'b1);
        consume(32'h8, 1'b1);
        tick(); tick(); tick();
        chk1("halt_no_req", mem_req, 1'b0);
        chk("halt_addr", mem_addr, 32'h8);
        exp_addr_q.push_back(32'h8);
        halt = 1'b0;
        tick();
        chk1("unhalt_req", mem_req, 1'b1);
        chk("unhalt_addr", mem_addr, 32'h8);
        exp_instr_q.push_back({32'h3333_3333, 32'h8});
        serve(32'h3333_3333, 1'b0, 1);

        // Bus error at 0x20
        exp_addr_q.push_back(32'h20);
        consume(32'h20, 1'b1);
        serve(32'h4444_4444, 1'b1, 0);
        chk1("err_fault", fetch_fault, 1'b1);
        chk("err_fault_addr", fault_addr, 32'h20);
        chk1("err_mem_req", mem_req, 1'b0);
        chk1("err_valid", instr_valid, 1'b0);
        chk1("err_busy", busy, 1'b0);

        // Timeout at 0x24
        rst = 1'b1;
        tick(); tick();
        chk1("rst2_fault", fetch_fault, 1'b0);
        chk("rst2_fault_addr", fault_addr, 32'h0);
        exp_addr_q.push_back(32'h0);
        exp_instr_q.push_back({32'h0000_0013, 32'h0});
        rst = 1'b0;
        serve(32'h0000_0013, 1'b0, 0);
        exp_addr_q.push_back(32'h24);
        consume(32'h24, 1'b1);
        n = 0;
        while (!fetch_fault && n < 100) begin
            if (mem_req) n++;
            tick();
        end
        chk("timeout_cycles", 32'(n), 32'd16);
        chk1("timeout_fault", fetch_fault, 1'b1);
        chk("timeout_addr", fault_addr, 32'h24);
        chk1("timeout_mem_req", mem_req, 1'b0);

        // Misaligned next_pc
        rst = 1'b1;
        tick(); tick();
        exp_addr_q.push_back(32'h0);
        exp_instr_q.push_back({32'h0000_0013, 32'h0});
        rst = 1'b0;
        serve(32'h0000_0013, 1'b0, 0);
        consume(32'h0000_0102, 1'b1);
        chk1("mis_fault", fetch_fault, 1'b1);
        chk("mis_addr", fault_addr, 32'h102);
        chk1("mis_mem_req", mem_req, 1'b0);
        pulse(32'h200);
        tick();
        chk1("mis_sticky", fetch_fault, 1'b1);
        chk("mis_addr_hold", fault_addr, 32'h102);
        chk1("mis_no_req", mem_req, 1'b0);
        rst = 1'b1;
        tick();
        chk1("rst3_fault", fetch_fault, 1'b0);
        chk("rst3_fault_addr", fault_addr, 32'h0);

        // Reset mid-fetch at 0x30
        tick();
        exp_addr_q.push_back(32'h0);
        exp_instr_q.push_back({32'h0000_0013, 32'h0});
        rst = 1'b0;
        serve(32'h0000_0013, 1'b0, 0);
        exp_addr_q.push_back(32'h30);
        consume(32'h30, 1'b1);
        tick();
        chk1("mid_req", mem_req, 1'b1);
        chk("mid_addr", mem_addr, 32'h30);
        halt = 1'b1;
        rst  = 1'b1;
        tick();
        chk1("mid_rst_req", mem_req, 1'b0);
        chk("mid_rst_addr", mem_addr, 32'h0);
        chk1("mid_rst_busy", busy, 1'b0);
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_5555;
        tick();
        mem_ack = 1'b0;
        tick();
        chk1("late_ack_valid", instr_valid, 1'b0);
        chk("late_ack_instr", instr, 32'h0);
        chk1("late_ack_req", mem_req, 1'b0);

        tick();
        chk("instr_q_empty", 32'(exp_instr_q.size()), 32'd0);
        chk("addr_q_empty", 32'(exp_addr_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
